// File: rtl/periph_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : periph_pkg
//  Purpose  : Register map, access-type encoding and hex glyph table shared
//             by the MMIO peripheral hub.
//  Revision : 1.0 - initial release
// ============================================================================
package periph_pkg;

    localparam logic [5:0] c_off_sw       = 6'h00;
    localparam logic [5:0] c_off_btn_edge = 6'h04;
    localparam logic [5:0] c_off_btn_lvl  = 6'h08;
    localparam logic [5:0] c_off_led      = 6'h10;
    localparam logic [5:0] c_off_led_set  = 6'h14;
    localparam logic [5:0] c_off_led_clr  = 6'h18;
    localparam logic [5:0] c_off_seg_data = 6'h20;
    localparam logic [5:0] c_off_seg_en   = 6'h24;

    typedef enum logic [1:0] {
        ACC_NONE = 2'd0,
        ACC_RO   = 2'd1,
        ACC_WO   = 2'd2,
        ACC_RW   = 2'd3
    } acc_e;

    typedef enum logic [3:0] {
        SEL_NONE     = 4'd0,
        SEL_SW       = 4'd1,
        SEL_BTN_EDGE = 4'd2,
        SEL_BTN_LVL  = 4'd3,
        SEL_LED      = 4'd4,
        SEL_LED_SET  = 4'd5,
        SEL_LED_CLR  = 4'd6,
        SEL_SEG_DATA = 4'd7,
        SEL_SEG_EN   = 4'd8
    } reg_sel_e;

    typedef struct packed {
        reg_sel_e sel;
        acc_e     acc;
    } reg_dec_t;

    // Active-low cathodes {dp,g,f,e,d,c,b,a}; entry n is the glyph for hex digit n.
    localparam logic [15:0][7:0] c_glyph = {
        8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
        8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

    function automatic reg_dec_t decode_reg(input logic [5:0] off);
        reg_dec_t d;
        d = '{sel: SEL_NONE, acc: ACC_NONE};
        case (off & 6'h3C)
            c_off_sw:       d = '{sel: SEL_SW,       acc: ACC_RO};
            c_off_btn_edge: d = '{sel: SEL_BTN_EDGE, acc: ACC_RO};
            c_off_btn_lvl:  d = '{sel: SEL_BTN_LVL,  acc: ACC_RO};
            c_off_led:      d = '{sel: SEL_LED,      acc: ACC_RW};
            c_off_led_set:  d = '{sel: SEL_LED_SET,  acc: ACC_WO};
            c_off_led_clr:  d = '{sel: SEL_LED_CLR,  acc: ACC_WO};
            c_off_seg_data: d = '{sel: SEL_SEG_DATA, acc: ACC_RW};
            c_off_seg_en:   d = '{sel: SEL_SEG_EN,   acc: ACC_RW};
            default:        d = '{sel: SEL_NONE,     acc: ACC_NONE};
        endcase
        return d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/periph_debounce.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : periph_debounce
//  Purpose  : 2-flop synchroniser plus tick-sampled debounce for W inputs.
//  Revision : 1.0 - initial release
// ============================================================================
module periph_debounce
    import periph_pkg::*;
#(
    parameter int W          = 1,
    parameter int DEB_CYCLES = 20000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] i_raw,
    output logic [W-1:0] o_level
);

    localparam int                 c_cnt_w   = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(DEB_CYCLES - 1);

    logic [W-1:0]       r_meta;
    logic [W-1:0]       r_sync;
    logic [W-1:0]       r_prev;
    logic [W-1:0]       r_level;
    logic [c_cnt_w-1:0] r_cnt;
    logic               w_tick;
    logic [W-1:0]       w_stable;

    assign w_tick   = (r_cnt == c_cnt_max);
    assign w_stable = ~(r_sync ^ r_prev);
    assign o_level  = r_level;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_meta  <= '0;
            r_sync  <= '0;
            r_prev  <= '0;
            r_level <= '0;
            r_cnt   <= '0;
        end else begin
            r_meta <= i_raw;
            r_sync <= r_meta;
            r_cnt  <= w_tick ? '0 : r_cnt + 1'b1;
            // A bit is accepted only when two consecutive ticks saw the same value.
            if (w_tick) begin
                r_prev  <= r_sync;
                r_level <= (r_sync & w_stable) | (r_level & ~w_stable);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mmio_periph_hub.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : mmio_periph_hub
//  Purpose  : Memory-mapped switches, buttons, LEDs and scanned 7-segment hub.
//  Revision : 1.0 - initial release
// ============================================================================
module mmio_periph_hub
    import periph_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'hFFFF_FC00,
    parameter int          SW_W       = 16,
    parameter int          BTN_N      = 5,
    parameter int          LED_W      = 24,
    parameter int          DIGITS     = 8,
    parameter int          DEB_CYCLES = 20000,
    parameter int          SCAN_DIV   = 50000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       addr,
    input  logic              rd_en,
    input  logic              wr_en,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              hit,
    input  logic [SW_W-1:0]   sw_in,
    input  logic [BTN_N-1:0]  btn_in,
    output logic [LED_W-1:0]  led_out,
    output logic [DIGITS-1:0] seg_an,
    output logic [7:0]        seg_cat
);

    localparam int                  c_idx_w    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int                  c_scan_w   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [c_idx_w-1:0]  c_idx_last = c_idx_w'(DIGITS - 1);
    localparam logic [c_scan_w-1:0] c_scan_max = c_scan_w'(SCAN_DIV - 1);

    logic [SW_W-1:0]     w_sw_lvl;
    logic [BTN_N-1:0]    w_btn_lvl;
    logic [BTN_N-1:0]    r_btn_prev;
    logic [BTN_N-1:0]    r_btn_edge;
    logic [BTN_N-1:0]    w_btn_rise;
    logic [LED_W-1:0]    r_led;
    logic [4*DIGITS-1:0] r_seg_data;
    logic [DIGITS-1:0]   r_seg_en;
    logic [c_scan_w-1:0] r_scan_cnt;
    logic [c_idx_w-1:0]  r_idx;
    logic [DIGITS-1:0]   r_an;
    logic [7:0]          r_cat;

    logic [31:0]         w_diff;
    reg_dec_t            w_dec;
    logic                w_rd_ok;
    logic                w_wr_ok;
    logic                w_edge_clr;
    logic [3:0]          w_nib;
    logic                w_dig_on;
    logic                w_unused;

    periph_debounce #(.W(SW_W), .DEB_CYCLES(DEB_CYCLES)) u_sw_deb (
        .clk     (clk),
        .rst     (rst),
        .i_raw   (sw_in),
        .o_level (w_sw_lvl)
    );

    periph_debounce #(.W(BTN_N), .DEB_CYCLES(DEB_CYCLES)) u_btn_deb (
        .clk     (clk),
        .rst     (rst),
        .i_raw   (btn_in),
        .o_level (w_btn_lvl)
    );

    // Subtraction keeps the window check correct for any base alignment.
    assign w_diff     = addr - BASE_ADDR;
    assign hit        = (addr >= BASE_ADDR) && (w_diff[31:6] == 26'd0);
    assign w_dec      = decode_reg(w_diff[5:0]);
    assign w_rd_ok    = rd_en && hit && (w_dec.acc == ACC_RO || w_dec.acc == ACC_RW);
    assign w_wr_ok    = wr_en && hit && (w_dec.acc == ACC_WO || w_dec.acc == ACC_RW);
    assign w_edge_clr = w_rd_ok && (w_dec.sel == SEL_BTN_EDGE);
    assign w_btn_rise = w_btn_lvl & ~r_btn_prev;
    assign w_unused   = ^{wdata, w_diff[1:0]};

    always_comb begin
        rdata = '0;
        if (w_rd_ok) begin
            case (w_dec.sel)
                SEL_SW:       rdata = 32'(w_sw_lvl);
                SEL_BTN_EDGE: rdata = 32'(r_btn_edge);
                SEL_BTN_LVL:  rdata = 32'(w_btn_lvl);
                SEL_LED:      rdata = 32'(r_led);
                SEL_SEG_DATA: rdata = 32'(r_seg_data);
                SEL_SEG_EN:   rdata = 32'(r_seg_en);
                default:      rdata = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_led      <= '0;
            r_seg_data <= '0;
            r_seg_en   <= '0;
        end else if (w_wr_ok) begin
            case (w_dec.sel)
                SEL_LED:      r_led      <= wdata[LED_W-1:0];
                SEL_LED_SET:  r_led      <= r_led | wdata[LED_W-1:0];
                SEL_LED_CLR:  r_led      <= r_led & ~wdata[LED_W-1:0];
                SEL_SEG_DATA: r_seg_data <= wdata[4*DIGITS-1:0];
                SEL_SEG_EN:   r_seg_en   <= wdata[DIGITS-1:0];
                default:      r_led      <= r_led;
            endcase
        end
    end

    // A rising edge arriving with a read-clear survives the clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_btn_prev <= '0;
            r_btn_edge <= '0;
        end else begin
            r_btn_prev <= w_btn_lvl;
            r_btn_edge <= (w_edge_clr ? '0 : r_btn_edge) | w_btn_rise;
        end
    end

    assign w_nib    = 4'(r_seg_data >> {r_idx, 2'b00});
    assign w_dig_on = |(r_seg_en & (DIGITS'(1) << r_idx));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_scan_cnt <= '0;
            r_idx      <= '0;
            r_an       <= '1;
            r_cat      <= 8'hFF;
        end else begin
            if (r_scan_cnt == c_scan_max) begin
                r_scan_cnt <= '0;
                r_idx      <= (r_idx == c_idx_last) ? '0 : r_idx + 1'b1;
            end else begin
                r_scan_cnt <= r_scan_cnt + 1'b1;
            end
            r_an  <= w_dig_on ? ~(DIGITS'(1) << r_idx) : '1;
            r_cat <= w_dig_on ? c_glyph[w_nib] : 8'hFF;
        end
    end

    assign led_out = r_led;
    assign seg_an  = r_an;
    assign seg_cat = r_cat;

endmodule
`default_nettype wire

// File: tb/tb_mmio_periph_hub.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_mmio_periph_hub
//  Purpose  : Self-checking bench for mmio_periph_hub with a behavioural model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mmio_periph_hub;

    localparam int          DEB  = 4;
    localparam int          SDIV = 2;
    localparam logic [31:0] BASE = 32'hFFFF_FC00;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] addr = '0;
    logic        rd_en = 1'b0;
    logic        wr_en = 1'b0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        hit;
    logic [15:0] sw_in = '0;
    logic [4:0]  btn_in = '0;
    logic [23:0] led_out;
    logic [7:0]  seg_an;
    logic [7:0]  seg_cat;

    int n_assert = 0;
    int n_fail   = 0;

    logic [7:0]  glyph [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    logic [23:0] m_led;
    logic [15:0] m_sw;
    logic [31:0] q;
    logic        h;

    mmio_periph_hub #(
        .BASE_ADDR  (BASE),
        .SW_W       (16),
        .BTN_N      (5),
        .LED_W      (24),
        .DIGITS     (8),
        .DEB_CYCLES (DEB),
        .SCAN_DIV   (SDIV)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .addr    (addr),
        .rd_en   (rd_en),
        .wr_en   (wr_en),
        .wdata   (wdata),
        .rdata   (rdata),
        .hit     (hit),
        .sw_in   (sw_in),
        .btn_in  (btn_in),
        .led_out (led_out),
        .seg_an  (seg_an),
        .seg_cat (seg_cat)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_range(input string tag, input int v, input int lo, input int hi);
        n_assert++;
        assert (v >= lo && v <= hi) else begin
            n_fail++;
            $error("FAIL %s: observed %0d required %0d..%0d", tag, v, lo, hi);
        end
    endtask

    task automatic bus(input logic rd, input logic wr, input logic [31:0] a,
                       input logic [31:0] d, output logic [31:0] rq, output logic rh);
        @(negedge clk);
        addr  = a;
        rd_en = rd;
        wr_en = wr;
        wdata = d;
        #1;
        rq = rdata;
        rh = hit;
        @(posedge clk);
        #1;
        rd_en = 1'b0;
        wr_en = 1'b0;
    endtask

    task automatic rd(input logic [5:0] off, output logic [31:0] rq);
        logic th;
        bus(1'b1, 1'b0, BASE + 32'(off), 32'h0, rq, th);
    endtask

    task automatic wr(input logic [5:0] off, input logic [31:0] d);
        logic [31:0] tq;
        logic        th;
        bus(1'b0, 1'b1, BASE + 32'(off), d, tq, th);
    endtask

    // Over one full rotation each enabled digit must be shown for SDIV cycles
    // with its own glyph; disabled slots must be fully blank.
    task automatic scan_check(input logic [31:0] data, input logic [7:0] en, input bit directed);
        logic [7:0] an_s  [32];
        logic [7:0] cat_s [32];
        int         dig   [32];
        int         cnt   [8];
        bit         pair;
        @(posedge clk);
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            an_s[i]  = seg_an;
            cat_s[i] = seg_cat;
        end
        for (int k = 0; k < 8; k++) cnt[k] = 0;
        pair = 1'b0;
        for (int i = 0; i < 32; i++) begin
            dig[i] = -1;
            for (int k = 0; k < 8; k++)
                if (an_s[i] == ~(8'h01 << k)) dig[i] = k;
            if (an_s[i] == 8'hFF) begin
                check("scan_blank_cat", {24'h0, cat_s[i]}, 32'h0000_00FF);
            end else begin
                check("scan_anode_valid", {31'h0, (dig[i] >= 0) && en[dig[i] & 7]}, 32'h1);
                if (dig[i] >= 0)
                    check("scan_glyph", {24'h0, cat_s[i]}, {24'h0, glyph[4'((data >> (4 * dig[i])) & 32'hF)]});
            end
            if (i < 16 && dig[i] >= 0) cnt[dig[i]]++;
            if (i > 0 && dig[i-1] == 0 && dig[i] == 1) pair = 1'b1;
        end
        for (int k = 0; k < 8; k++)
            check("scan_dwell", 32'(cnt[k]), en[k] ? 32'(SDIV) : 32'h0);
        if (directed) check("scan_digit0_then_1", {31'h0, pair}, 32'h1);
    endtask

    initial begin
        int          first;
        int          bad;
        int          ones;
        logic [15:0] nsw;
        logic [31:0] d;
        logic [31:0] sd;
        logic [7:0]  se;
        logic [4:0]  mask;

        // ---------------- reset and idle ----------------
        repeat (3) @(posedge clk);
        #1;
        check("rst_led", {8'h0, led_out}, 32'h0);
        check("rst_an", {24'h0, seg_an}, 32'h0000_00FF);
        check("rst_cat", {24'h0, seg_cat}, 32'h0000_00FF);
        @(negedge clk);
        rst = 1'b1;
        rd(6'h00, q); check("idle_sw", q, 32'h0);
        rd(6'h04, q); check("idle_btn_edge", q, 32'h0);
        rd(6'h08, q); check("idle_btn_lvl", q, 32'h0);
        rd(6'h10, q); check("idle_led", q, 32'h0);
        check("idle_an", {24'h0, seg_an}, 32'h0000_00FF);
        m_led = '0;
        m_sw  = '0;

        // ---------------- LED register and aliases ----------------
        wr(6'h10, 32'h00A5_A5A5);
        wr(6'h14, 32'h0F00_0000);
        check("led_set_high_dropped", {8'h0, led_out}, 32'h00A5_A5A5);
        wr(6'h18, 32'h0000_00FF);
        check("led_clr", {8'h0, led_out}, 32'h00A5_A500);
        rd(6'h10, q); check("led_read", q, 32'h00A5_A500);
        m_led = 24'hA5A500;
        for (int i = 0; i < 16; i++) begin
            d = $urandom;
            case ($urandom_range(0, 2))
                0: begin wr(6'h10, d); m_led = d[23:0]; end
                1: begin wr(6'h14, d); m_led = m_led | d[23:0]; end
                default: begin wr(6'h18, d); m_led = m_led & ~d[23:0]; end
            endcase
            check("led_rand_out", {8'h0, led_out}, {8'h0, m_led});
            rd(6'h10, q); check("led_rand_read", q, {8'h0, m_led});
        end
        d = $urandom;
        bus(1'b1, 1'b1, BASE + 32'h10, d, q, h);
        check("led_rw_same_cycle_old", q, {8'h0, m_led});
        m_led = d[23:0];
        check("led_rw_same_cycle_new", {8'h0, led_out}, {8'h0, m_led});

        // ---------------- switch debounce ----------------
        for (int t = 0; t < 5; t++) begin
            nsw = (t == 0) ? 16'h8001 : 16'($urandom);
            if (nsw == m_sw) nsw = nsw ^ 16'h0001;
            @(negedge clk);
            addr  = BASE;
            rd_en = 1'b1;
            @(posedge clk);
            #1;
            sw_in = nsw;
            first = 0;
            bad   = 0;
            for (int n = 1; n <= 2 * DEB + 6; n++) begin
                @(posedge clk);
                #1;
                if (first == 0 && rdata == {16'h0, nsw}) first = n;
                if (rdata != {16'h0, nsw} && rdata != {16'h0, m_sw}) bad++;
            end
            check_range("sw_settle_cycles", first, DEB + 3, 2 * DEB + 3);
            check("sw_no_partial", 32'(bad), 32'h0);
            check("sw_final", rdata, {16'h0, nsw});
            m_sw = nsw;
        end
        @(posedge clk);
        #1;
        sw_in = m_sw ^ 16'h0008;
        repeat (2) @(posedge clk);
        #1;
        sw_in = m_sw;
        bad = 0;
        for (int n = 0; n < 4 * DEB; n++) begin
            @(posedge clk);
            #1;
            if (rdata != {16'h0, m_sw}) bad++;
        end
        check("sw_glitch_blocked", 32'(bad), 32'h0);
        rd_en = 1'b0;

        // ---------------- button edge flags ----------------
        @(posedge clk);
        #1;
        btn_in = 5'b00100;
        repeat (2 * DEB + 8) @(posedge clk);
        rd(6'h04, q); check("btn2_edge", q, 32'h4);
        rd(6'h04, q); check("btn2_edge_cleared", q, 32'h0);
        rd(6'h08, q); check("btn2_level", q, 32'h4);
        @(posedge clk);
        #1;
        btn_in = 5'b00000;
        repeat (2 * DEB + 8) @(posedge clk);
        rd(6'h08, q); check("btn_release_level", q, 32'h0);
        rd(6'h04, q); check("btn_release_no_edge", q, 32'h0);

        @(negedge clk);
        addr  = BASE + 32'h04;
        rd_en = 1'b1;
        @(posedge clk);
        #1;
        btn_in = 5'b00001;
        ones = 0;
        for (int n = 0; n < 3 * DEB + 10; n++) begin
            @(negedge clk);
            if (rdata == 32'h1) ones++;
        end
        rd_en = 1'b0;
        check("btn0_edge_survives_clear", 32'(ones), 32'h1);
        rd(6'h08, q); check("btn0_level", q, 32'h1);

        @(posedge clk);
        #1;
        btn_in = 5'b00000;
        repeat (2 * DEB + 8) @(posedge clk);
        rd(6'h04, q);
        mask = 5'($urandom_range(1, 31));
        @(posedge clk);
        #1;
        btn_in = mask;
        repeat (2 * DEB + 8) @(posedge clk);
        rd(6'h04, q); check("btn_rand_edge", q, {27'h0, mask});
        rd(6'h08, q); check("btn_rand_level", q, {27'h0, mask});
        rd(6'h04, q); check("btn_rand_cleared", q, 32'h0);

        // ---------------- display scan ----------------
        wr(6'h20, 32'h0000_003A);
        wr(6'h24, 32'h0000_0003);
        scan_check(32'h0000_003A, 8'h03, 1'b1);
        for (int t = 0; t < 2; t++) begin
            sd = $urandom;
            se = 8'($urandom_range(1, 255));
            wr(6'h20, sd);
            wr(6'h24, {24'h0, se});
            rd(6'h20, q); check("seg_data_read", q, sd);
            rd(6'h24, q); check("seg_en_read", q, {24'h0, se});
            scan_check(sd, se, 1'b0);
        end

        // ---------------- bus corner cases ----------------
        wr(6'h00, 32'hFFFF_FFFF);
        rd(6'h00, q); check("sw_write_ignored", q, {16'h0, m_sw});
        rd(6'h3C, q); check("unmapped_read", q, 32'h0);
        rd(6'h14, q); check("wo_read_zero", q, 32'h0);
        bus(1'b1, 1'b0, BASE + 32'h40, 32'h0, q, h);
        check("above_window_hit", {31'h0, h}, 32'h0);
        check("above_window_rdata", q, 32'h0);
        bus(1'b1, 1'b0, BASE - 32'h4, 32'h0, q, h);
        check("below_window_hit", {31'h0, h}, 32'h0);
        bus(1'b0, 1'b0, BASE + 32'h10, 32'h0, q, h);
        check("no_rd_en_hit", {31'h0, h}, 32'h1);
        check("no_rd_en_rdata", q, 32'h0);
        bus(1'b0, 1'b1, BASE + 32'h50, 32'hFFFF_FFFF, q, h);
        check("miss_write_ignored", {8'h0, led_out}, {8'h0, m_led});

        // ---------------- asynchronous reset mid-scan ----------------
        bad = 1;
        for (int n = 0; n < 40 && bad != 0; n++) begin
            @(negedge clk);
            if (seg_an != 8'hFF) bad = 0;
        end
        check("scan_active_before_reset", 32'(bad), 32'h0);
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_an", {24'h0, seg_an}, 32'h0000_00FF);
        check("async_rst_cat", {24'h0, seg_cat}, 32'h0000_00FF);
        check("async_rst_led", {8'h0, led_out}, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        rd(6'h00, q); check("post_rst_sw", q, 32'h0);
        rd(6'h24, q); check("post_rst_seg_en", q, 32'h0);
        rd(6'h20, q); check("post_rst_seg_data", q, 32'h0);
        rd(6'h10, q); check("post_rst_led", q, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
